gpio_input_conditioner: RTL and testbench
=========================================

Name: gpio_input_conditioner

Overview:
- Input conditioning stage directly upstream of the JP2 expansion-header parallel port.
- Takes the 32 raw input bits gathered from the header and passes them through a 2-FF synchroniser, then a per-bit debounce filter.
- Outputs a clean level vector, which the parallel port samples in place of the raw pins. Also outputs one-cycle rise/fall event pulses, so edge capture sees exactly one edge per physical transition (no contact bounce).

Parameters:
- DW, 31: data width minus 1 (number of conditioned bits = DW+1).
- TICK_DIV, 50000: clk cycles per debounce tick (1 ms at 50 MHz); legal range >= 1.
- CW, 8: width of the debounce threshold and per-bit counters.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- pins_in  in  DW+1  raw asynchronous header inputs.
- enable  in  1  1 = filter active; 0 = freeze the outputs.
- db_threshold  in  CW  ticks an input must stay stable before it is accepted; 0 = bypass.
- data_clean  out  DW+1  debounced level vector.
- rise  out  DW+1  one-cycle pulse per bit on an accepted 0->1 change.
- fall  out  DW+1  one-cycle pulse per bit on an accepted 1->0 change.
- changed  out  1  OR of rise|fall, registered together with them.

Behaviour:
- Reset values: all synchroniser flops, data_clean, rise, fall, changed, prescaler and per-bit counters are 0.
- Consequence of reset: pins held high through reset produce a rise once the debounce completes. This is intended.
- Synchroniser:
  - s1 <= pins_in; s2 <= s1, every clk, independent of enable.
  - s2 is the filtered input "sync".
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick = 1 for exactly the one cycle where count == TICK_DIV-1.
  - With TICK_DIV=1, tick is constantly 1.
  - Free-running; not reset by enable.
- Per-bit filter, two states:
  - STABLE (sync == clean): counter forced to 0 every cycle.
  - PENDING (sync != clean): the counter increments on tick.
  - Commit condition: tick && mismatch && counter >= db_threshold-1.
  - On commit, next edge: clean <= sync, counter <= 0, and a rise or fall pulse for exactly 1 cycle.
  - Any cycle where sync returns to clean aborts the pending change: counter <= 0, no pulse.
  - The counter saturates at 2^CW-1 and never wraps.
- Threshold rules:
  - Latency from a stable sync change to data_clean is N mismatched ticks, committed on the edge after the Nth tick, for threshold N >= 1.
  - db_threshold == 0: clean <= sync every cycle (no tick dependency). Pulses are still generated on each change. Total latency pins_in -> data_clean = 3 clk.
  - db_threshold lowered mid-count: the >= compare commits on the next tick.
  - db_threshold raised mid-count: counting continues toward the new value.
- enable == 0:
  - data_clean holds.
  - Counters are forced to 0.
  - rise/fall/changed are 0.
  - On re-enable, pending differences restart a full debounce.
- Simultaneous events: bits are fully independent. Several bits may pulse in the same cycle, and changed is asserted once for that cycle.
- Reset mid-debounce: all state clears on the next edge and no pulse is emitted. Reset has priority over enable and tick.
- Outputs are registered: rise/fall/changed are aligned to the same cycle data_clean takes its new value.

Decomposition:
- Shared package gpio_cond_pkg holds:
  - the default DW/CW/TICK_DIV constants;
  - the state encoding localparams ST_STABLE / ST_PENDING (1-bit, implied by the compare).
- One natural sub-module, gpio_debounce_bit:
  - holds the counter, clean flop and pulse flops for one bit;
  - ports: clk, reset, enable, tick, sync, threshold, clean, rise, fall.
- Top level contains the synchroniser, the prescaler, the generate loop of DW+1 instances, and the changed OR-reduce register.

Test Plan (TICK_DIV=4, CW=8):
1. Clean step: reset, threshold=3, pins_in[0] 0->1 held. Required: data_clean[0]=1 and rise[0]=1 for 1 cycle after the 3rd mismatched tick (within 2+12+4 clk). fall stays 0. changed pulses with rise.
2. Bounce rejection: threshold=3, pins_in[5] toggles every 5 clk for 40 clk, then settles at 1. Required: no pulse during toggling, exactly one rise[5] after settling, data_clean[5]=1.
3. Bypass: threshold=0, pins_in = 0xA5A5_0F0F. Required: data_clean = 0xA5A5_0F0F exactly 3 clk later; rise = 0xA5A5_0F0F for 1 cycle; fall = 0.
4. Enable freeze: data_clean=0xFFFF_FFFF, enable=0, pins_in=0, wait 100 clk. Required: data_clean unchanged, no pulses. Set enable=1 with threshold=2: fall = 0xFFFF_FFFF for one cycle after 2 ticks.
5. Simultaneous / mixed: bit 3 rises while bit 7 falls, same timing, threshold=1. Required: rise=0x8 and fall=0x80 in the same cycle, and changed=1 for one cycle only.
6. Reset mid-operation: threshold=5, bit 0 pending after 3 ticks, assert reset 1 clk. Required: all outputs 0 next cycle, no pulse. After reset deasserts with the pin still high, the full 5-tick debounce must elapse before rise[0].

Source files
------------

// File: rtl/gpio_cond_pkg.sv
// Shared constants for the GPIO input conditioner: default widths, tick divider
// and the per-bit filter state encoding.
package gpio_cond_pkg;

    localparam int DEF_DW       = 31;
    localparam int DEF_TICK_DIV = 50000;
    localparam int DEF_CW       = 8;

    localparam logic ST_STABLE  = 1'b0;
    localparam logic ST_PENDING = 1'b1;

endpackage

// File: rtl/gpio_input_conditioner_if.sv
// Bus between the conditioner and the parallel port: raw pins and controls in,
// clean levels and edge events out.
interface gpio_cond_if
    import gpio_cond_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int CW = DEF_CW
);
    logic [DW:0]   pins_in;
    logic          enable;
    logic [CW-1:0] db_threshold;
    logic [DW:0]   data_clean;
    logic [DW:0]   rise;
    logic [DW:0]   fall;
    logic          changed;

    modport master (
        output pins_in, enable, db_threshold,
        input  data_clean, rise, fall, changed
    );

    modport slave (
        input  pins_in, enable, db_threshold,
        output data_clean, rise, fall, changed
    );
endinterface

// File: rtl/gpio_debounce_bit.sv
// One-bit debounce filter: accepts a synchronised level once it has differed
// from the clean level for `threshold` ticks, and emits a one-cycle edge pulse.
//   state      | meaning
//   ST_STABLE  | sync == clean, counter held at 0
//   ST_PENDING | sync != clean, counter advances on tick until threshold
module gpio_debounce_bit
    import gpio_cond_pkg::*;
#(
    parameter int CW = DEF_CW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          tick,
    input  logic          sync,
    input  logic [CW-1:0] threshold,
    output logic          clean,
    output logic          rise,
    output logic          fall,
    output logic          pulse_nxt
);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          clean_q, clean_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic          state;

    always_comb begin
        state   = (sync != clean_q) ? ST_PENDING : ST_STABLE;
        cnt_d   = cnt_q;
        clean_d = clean_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (!enable) begin
            cnt_d = '0;
        end else if (threshold == '0) begin
            clean_d = sync;
            cnt_d   = '0;
            rise_d  = (state == ST_PENDING) && sync;
            fall_d  = (state == ST_PENDING) && !sync;
        end else if (state == ST_STABLE) begin
            cnt_d = '0;
        end else if (tick) begin
            // >= rather than == so a threshold lowered mid-count commits on the next tick
            if (cnt_q >= threshold - CW'(1)) begin
                clean_d = sync;
                cnt_d   = '0;
                rise_d  = sync;
                fall_d  = !sync;
            end else if (cnt_q != '1) begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            clean_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign clean     = clean_q;
    assign rise      = rise_q;
    assign fall      = fall_q;
    // Next-cycle pulse lets the top register `changed` alongside rise/fall.
    assign pulse_nxt = rise_d | fall_d;

endmodule

// File: rtl/gpio_input_conditioner.sv
// Header-input conditioner: 2-FF synchroniser, free-running debounce tick
// prescaler and one debounce filter per bit, plus the registered `changed` flag.
module gpio_input_conditioner
    import gpio_cond_pkg::*;
#(
    parameter int DW       = DEF_DW,
    parameter int TICK_DIV = DEF_TICK_DIV,
    parameter int CW       = DEF_CW
) (
    input logic        clk,
    input logic        reset,
    gpio_cond_if.slave io
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [DW:0]   s1_q, s1_d;
    logic [DW:0]   s2_q, s2_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          changed_q, changed_d;
    logic          tick;
    logic [DW:0]   pulse_nxt;

    always_comb begin
        s1_d      = io.pins_in;
        s2_d      = s1_q;
        tick      = (pre_q == PW'(TICK_DIV - 1));
        pre_d     = tick ? '0 : pre_q + PW'(1);
        changed_d = |pulse_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q      <= '0;
            s2_q      <= '0;
            pre_q     <= '0;
            changed_q <= 1'b0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            pre_q     <= pre_d;
            changed_q <= changed_d;
        end
    end

    for (genvar i = 0; i <= DW; i++) begin : g_bit
        gpio_debounce_bit #(.CW(CW)) u_bit (
            .clk       (clk),
            .reset     (reset),
            .enable    (io.enable),
            .tick      (tick),
            .sync      (s2_q[i]),
            .threshold (io.db_threshold),
            .clean     (io.data_clean[i]),
            .rise      (io.rise[i]),
            .fall      (io.fall[i]),
            .pulse_nxt (pulse_nxt[i])
        );
    end

    assign io.changed = changed_q;

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Bench for gpio_input_conditioner: directed scenarios with literal expectations
// plus random traffic, all compared each cycle against a behavioural model.
module tb_gpio_input_conditioner;
    localparam int DW   = 31;
    localparam int CW   = 8;
    localparam int TDIV = 4;

    logic clk;
    logic reset;

    gpio_cond_if #(.DW(DW), .CW(CW)) bus ();

    gpio_input_conditioner #(.DW(DW), .TICK_DIV(TDIV), .CW(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .io    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: pipeline of two samples, count of mismatched ticks per bit.
    logic [31:0] m_s1, m_s2, m_clean, m_rise, m_fall;
    logic        m_changed;
    int          m_pend [32];
    int          m_pre;
    bit          model_valid = 0;

    always @(posedge clk) begin
        bit          tk;
        logic [31:0] r, f;
        int          thr;
        tk  = (m_pre == TDIV - 1);
        thr = int'(bus.db_threshold);
        if (reset) begin
            m_s1 = 0; m_s2 = 0; m_clean = 0; m_rise = 0; m_fall = 0; m_changed = 0;
            for (int b = 0; b < 32; b++) m_pend[b] = 0;
            m_pre = 0;
            model_valid = 1;
        end else if (model_valid) begin
            r = 0; f = 0;
            for (int b = 0; b < 32; b++) begin
                if (!bus.enable || m_s2[b] == m_clean[b]) begin
                    m_pend[b] = 0;
                end else if (thr == 0) begin
                    r[b] = m_s2[b]; f[b] = !m_s2[b];
                end else if (tk) begin
                    if (m_pend[b] + 1 >= thr) begin
                        r[b] = m_s2[b]; f[b] = !m_s2[b]; m_pend[b] = 0;
                    end else begin
                        m_pend[b] = (m_pend[b] + 1 > 255) ? 255 : m_pend[b] + 1;
                    end
                end
            end
            m_clean   = m_clean ^ (r | f);
            m_rise    = r;
            m_fall    = f;
            m_changed = |(r | f);
            m_pre     = (m_pre + 1) % TDIV;
            m_s2      = m_s1;
            m_s1      = bus.pins_in;
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            check("mdl_data_clean", bus.data_clean, m_clean);
            check("mdl_rise", bus.rise, m_rise);
            check("mdl_fall", bus.fall, m_fall);
            check("mdl_changed", 32'(bus.changed), 32'(m_changed));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    int lat, cnt_a, cnt_b;
    bit found;

    initial begin
        reset = 1'b1;
        bus.enable = 1'b1;
        bus.db_threshold = 8'd3;
        bus.pins_in = '0;
        cyc(3);
        check("reset_clean", bus.data_clean, 32'h0);
        check("reset_pulses", bus.rise | bus.fall, 32'h0);
        reset = 1'b0;
        cyc(10);

        // 1: clean step on bit 0, threshold 3
        bus.pins_in[0] = 1'b1;
        found = 0; lat = 0; cnt_a = 0;
        for (int k = 1; k <= 24 && !found; k++) begin
            cyc(1);
            if (bus.fall != 0) cnt_a++;
            if (bus.rise[0]) begin
                found = 1; lat = k;
                check("t1_clean0", 32'(bus.data_clean[0]), 32'd1);
                check("t1_changed", 32'(bus.changed), 32'd1);
            end
        end
        check("t1_found", 32'(found), 32'd1);
        check("t1_latency_window", 32'(lat >= 11 && lat <= 14), 32'd1);
        check("t1_no_fall", 32'(cnt_a), 32'd0);
        cyc(1);
        check("t1_rise_one_cycle", bus.rise, 32'h0);

        // 2: bounce rejection on bit 5
        cnt_a = 0;
        for (int k = 0; k < 40; k++) begin
            if (k % 5 == 0) bus.pins_in[5] = ~bus.pins_in[5];
            cyc(1);
            if (bus.rise[5] || bus.fall[5]) cnt_a++;
        end
        bus.pins_in[5] = 1'b1;
        cnt_b = 0;
        for (int k = 0; k < 30; k++) begin
            cyc(1);
            if (bus.rise[5]) cnt_b++;
            if (bus.fall[5]) cnt_a++;
        end
        check("t2_no_bounce_pulse", 32'(cnt_a), 32'd0);
        check("t2_one_rise", 32'(cnt_b), 32'd1);
        check("t2_clean5", 32'(bus.data_clean[5]), 32'd1);

        // 3: bypass
        reset = 1'b1; bus.pins_in = '0;
        cyc(2);
        reset = 1'b0; bus.db_threshold = 8'd0;
        cyc(3);
        bus.pins_in = 32'hA5A5_0F0F;
        cyc(2);
        check("t3_not_yet", bus.data_clean, 32'h0);
        cyc(1);
        check("t3_clean", bus.data_clean, 32'hA5A5_0F0F);
        check("t3_rise", bus.rise, 32'hA5A5_0F0F);
        check("t3_fall", bus.fall, 32'h0);
        check("t3_changed", 32'(bus.changed), 32'd1);
        cyc(1);
        check("t3_rise_cleared", bus.rise, 32'h0);

        // 4: enable freeze
        bus.pins_in = 32'hFFFF_FFFF;
        cyc(4);
        check("t4_all_ones", bus.data_clean, 32'hFFFF_FFFF);
        bus.enable = 1'b0; bus.pins_in = '0;
        cnt_a = 0; cnt_b = 0;
        for (int k = 0; k < 100; k++) begin
            cyc(1);
            if (bus.data_clean != 32'hFFFF_FFFF) cnt_a++;
            if ((bus.rise | bus.fall) != 0 || bus.changed) cnt_b++;
        end
        check("t4_hold", 32'(cnt_a), 32'd0);
        check("t4_no_pulse", 32'(cnt_b), 32'd0);
        bus.db_threshold = 8'd2; bus.enable = 1'b1;
        found = 0; lat = 0;
        for (int k = 1; k <= 16 && !found; k++) begin
            cyc(1);
            if (bus.fall != 0) begin
                found = 1; lat = k;
                check("t4_fall", bus.fall, 32'hFFFF_FFFF);
                check("t4_rise", bus.rise, 32'h0);
                check("t4_clean", bus.data_clean, 32'h0);
            end
        end
        check("t4_latency_window", 32'(found && lat >= 5 && lat <= 8), 32'd1);

        // 5: simultaneous rise on bit 3 and fall on bit 7
        bus.db_threshold = 8'd1;
        bus.pins_in = 32'h80;
        cyc(14);
        check("t5_setup", bus.data_clean, 32'h80);
        bus.pins_in = 32'h08;
        found = 0;
        for (int k = 1; k <= 12 && !found; k++) begin
            cyc(1);
            if (bus.changed) begin
                found = 1;
                check("t5_rise", bus.rise, 32'h08);
                check("t5_fall", bus.fall, 32'h80);
            end
        end
        check("t5_found", 32'(found), 32'd1);
        cyc(1);
        check("t5_changed_one_cycle", 32'(bus.changed), 32'd0);

        // 6: reset mid-debounce, then full 5-tick debounce
        bus.db_threshold = 8'd5;
        bus.pins_in = 32'h09;
        cyc(14);
        check("t6_pending", 32'(bus.data_clean[0]), 32'd0);
        reset = 1'b1; bus.pins_in = 32'h01;
        cyc(1);
        check("t6_rst_clean", bus.data_clean, 32'h0);
        check("t6_rst_pulses", bus.rise | bus.fall, 32'h0);
        check("t6_rst_changed", 32'(bus.changed), 32'd0);
        reset = 1'b0;
        found = 0; lat = 0;
        for (int k = 1; k <= 30 && !found; k++) begin
            cyc(1);
            if (bus.rise[0]) begin found = 1; lat = k; end
        end
        check("t6_latency", 32'(lat), 32'd20);

        // random traffic against the model
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 99) < 8) bus.pins_in = bus.pins_in ^ ($urandom & $urandom & $urandom);
            if ($urandom_range(0, 3) == 0) bus.pins_in[15:12] = bus.pins_in[15:12] ^ 4'($urandom);
            if ($urandom_range(0, 199) == 0) bus.db_threshold = 8'($urandom_range(0, 4));
            if ($urandom_range(0, 149) == 0) bus.enable = ~bus.enable;
            reset = ($urandom_range(0, 999) == 0);
            cyc(1);
        end
        reset = 1'b0; bus.enable = 1'b1;
        cyc(40);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog timeout tests=%0d", tests);
        $fatal(1, "watchdog");
    end

endmodule
